// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative RV32M multiply/divide unit. One operation is in flight at a time.
//   It runs a 32-step shift-add multiply or a restoring divide on operand
//   magnitudes, then applies the signs in a fix-up cycle.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   flush            abort any in-flight operation (no response is issued)
//   req_valid/ready  request handshake; req_ready only while IDLE and not flushing
//   req_funct3       M-extension funct3 (MUL..REMU)
//   req_rs1/rs2      multiplicand/dividend, multiplier/divisor
//   req_rd           destination tag, returned with the result
//   resp_valid/ready response handshake; data and tag held until accepted
//   resp_data/rd     result word and its tag
//   busy             high whenever the unit is not IDLE
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   rs1_q, rs2_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   a_mag_q, b_mag_q;
    logic [XLEN-1:0]   opsr_q;        // multiplier (shifts right) or dividend (shifts left)
    logic [2*XLEN-1:0] acc_q;         // {hi, lo} product, or {remainder, quotient}
    logic [5:0]        cnt_q;
    logic              special_q;
    logic [XLEN-1:0]   spec_res_q;
    logic [XLEN-1:0]   res_q;

    logic accept;
    logic req_sign_a, req_sign_b;
    logic is_div, div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] a_mag, b_mag;

    assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = res_q;
    assign resp_rd    = rd_q;

    // Signedness: MULHSU keeps rs1 signed but rs2 unsigned; *U ops are fully unsigned.
    assign req_sign_a = req_rs1[XLEN-1] &&
                        (req_funct3 inside {F_MUL, F_MULH, F_MULHSU, F_DIV, F_REM});
    assign req_sign_b = req_rs2[XLEN-1] &&
                        (req_funct3 inside {F_MUL, F_MULH, F_DIV, F_REM});

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct
    // when read as unsigned.
    assign a_mag = neg_a_q ? -rs1_q : rs1_q;
    assign b_mag = neg_b_q ? -rs2_q : rs2_q;

    assign is_div   = f3_q[2];
    assign div_zero = is_div && (rs2_q == '0);
    assign div_ovf  = (f3_q inside {F_DIV, F_REM}) &&
                      (rs1_q == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_q == '1);
    assign special  = div_zero || div_ovf;

    // f3_q[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = f3_q[1] ? rs1_q : '1;
        else if (div_ovf)
            spec_res = f3_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One multiply step: conditional add into the high half, then shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc;
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (opsr_q[0] ? a_mag_q : '0)};
    assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

    // One divide step: shift the next dividend bit into the remainder, trial-subtract.
    // When the subtraction succeeds the true difference is below the divisor, so
    // the low XLEN bits of the difference are exact.
    logic [XLEN:0]     rem_sh;
    logic              ge;
    logic [XLEN-1:0]   diff, new_rem;
    logic [2*XLEN-1:0] div_acc;
    assign rem_sh  = {acc_q[2*XLEN-1:XLEN], opsr_q[XLEN-1]};
    assign ge      = rem_sh >= {1'b0, b_mag_q};
    assign diff    = rem_sh[XLEN-1:0] - b_mag_q;
    assign new_rem = ge ? diff : rem_sh[XLEN-1:0];
    assign div_acc = {new_rem, acc_q[XLEN-2:0], ge};

    // Sign fix-up and result select.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, result;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        result = '0;
        case (f3_q)
            F_MUL:                    result = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            F_DIV, 3'b101:            result = quo_fix;
            default:                  result = rem_fix;
        endcase
    end

    // Special cases skip CALC but still leave through FIXUP, so their response
    // appears two edges after accept on the same registered path as normal results.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_PREP;
                S_PREP:  state_d = special ? S_FIXUP : S_CALC;
                S_CALC:  if (cnt_q == 6'(XLEN-1)) state_d = S_FIXUP;
                S_FIXUP: state_d = S_DONE;
                S_DONE:  if (resp_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            opsr_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            res_q      <= '0;
        end else if (flush) begin
            cnt_q     <= '0;
            special_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        f3_q    <= req_funct3;
                        rd_q    <= req_rd;
                        rs1_q   <= req_rs1;
                        rs2_q   <= req_rs2;
                        neg_a_q <= req_sign_a;
                        neg_b_q <= req_sign_b;
                    end
                end
                S_PREP: begin
                    a_mag_q    <= a_mag;
                    b_mag_q    <= b_mag;
                    opsr_q     <= is_div ? a_mag : b_mag;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    special_q  <= special;
                    spec_res_q <= spec_res;
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (is_div) begin
                        acc_q  <= div_acc;
                        opsr_q <= {opsr_q[XLEN-2:0], 1'b0};
                    end else begin
                        acc_q  <= mul_acc;
                        opsr_q <= {1'b0, opsr_q[XLEN-1:1]};
                    end
                end
                S_FIXUP: begin
                    res_q <= special_q ? spec_res_q : result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        busy;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
    } sb_t;

    sb_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Drive one request and let it be accepted at the next edge (E0).
    task automatic send(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit track);
        sb_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_rd     = rd;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        if (track) begin
            e.data = exp; e.rd = rd; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Wait (bounded) for the response, compare against the scoreboard, optionally
    // hold resp_ready low for a few cycles, then accept it.
    task automatic expect_resp(input int hold);
        int n;
        sb_t e;
        logic [31:0] d0;
        logic [4:0]  r0;
        n = 0;
        while (!resp_valid && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("resp_arrived", {63'd0, resp_valid}, 64'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk("latency", 64'(n), 64'(e.lat));
            chk("resp_data", {32'd0, resp_data}, {32'd0, e.data});
            chk("resp_rd", {59'd0, resp_rd}, {59'd0, e.rd});
        end
        d0 = resp_data;
        r0 = resp_rd;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_data", {32'd0, resp_data}, {32'd0, d0});
            chk("bp_rd", {59'd0, resp_rd}, {59'd0, r0});
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("post_accept_valid", {63'd0, resp_valid}, 64'd0);
        chk("post_accept_busy", {63'd0, busy}, 64'd0);
        chk("post_accept_req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    // Start a MUL, abort it at CALC iteration 10 with flush or rst, then run DIV 9/3.
    task automatic abort_scenario(input bit use_rst);
        send(3'b000, 32'd123, 32'd456, 5'd20, 32'd0, 0, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        chk("mid_calc_busy", {63'd0, busy}, 64'd1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        #1;
        chk("abort_req_ready_low", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_valid", {63'd0, resp_valid}, 64'd0);
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        send(3'b100, 32'd9, 32'd3, 5'd21, 32'd3, 34, 1'b1);
        expect_resp(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[18];
        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34}; // MUL 7*-3
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34}; // MULH
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34}; // MULHU
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34}; // MULHSU
        vecs[4]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34}; // MUL -1*-1
        vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34}; // DIV -7/2
        vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34}; // REM -7/2
        vecs[7]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34}; // DIVU
        vecs[8]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34}; // REMU
        vecs[9]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2};  // DIVU /0
        vecs[10] = '{3'b111, 32'd5,        32'd0,        32'd5,        2};  // REMU /0
        vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};  // DIV ovf
        vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};  // REM ovf
        vecs[13] = '{3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 2};  // DIV -5/0
        vecs[14] = '{3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2};  // REM -5/0
        vecs[15] = '{3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34}; // DIV min/2
        vecs[16] = '{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34}; // MULH 7*-3
        vecs[17] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        34}; // MULH -1*-1

        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_rd     = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_data", {32'd0, resp_data}, 64'd0);
        chk("reset_rd", {59'd0, resp_rd}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_req_ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, 5'(i + 1), vecs[i].exp, vecs[i].lat, 1'b1);
            expect_resp(i == 0 ? 5 : 0);
        end

        abort_scenario(1'b0);
        abort_scenario(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
